// File: rtl/setup_pkg.sv
// rtl/setup_pkg.sv - shared types, key codes and per-item range/reset tables for setup mode
package setup_pkg;

  localparam int NUM_CFG    = 8;
  localparam int CFG_DIG    = 4;
  localparam int MASTER_LEN = 4;
  // Key buffer must hold the longest PIN plus the terminating key.
  localparam int SENHA_NIB  = 20;

  localparam logic [3:0] KEY_STAR = 4'hA;
  localparam logic [3:0] KEY_HASH = 4'hB;
  localparam logic [3:0] KEY_NONE = 4'hF;

  typedef logic [CFG_DIG*4-1:0]      cfg_val_t;
  typedef cfg_val_t [NUM_CFG-1:0]    cfg_arr_t;
  typedef logic [5:0][3:0]           bcdPac_t;
  typedef logic [SENHA_NIB-1:0][3:0] senhaPac_t;

  typedef struct packed {
    cfg_arr_t data;
    logic     ok;
  } setupPac_t;

  typedef enum logic [1:0] {ST_IDLE, ST_AUTH, ST_CFG} state_t;

  // Item 0 is the rightmost entry.
  localparam cfg_arr_t CFG_RST = {16'h0000, 16'h1234, 16'h0060, 16'h0002,
                                  16'h0100, 16'h0005, 16'h0010, 16'h0030};
  localparam cfg_arr_t CFG_MIN = {16'h0000, 16'h0000, 16'h0000, 16'h0000,
                                  16'h0010, 16'h0001, 16'h0001, 16'h0010};
  localparam cfg_arr_t CFG_MAX = {16'h9999, 16'h9999, 16'h0999, 16'h0009,
                                  16'h5000, 16'h0030, 16'h0060, 16'h0099};

endpackage

// File: rtl/setup_entry_parse.sv
// rtl/setup_entry_parse.sv - combinational decode of the key buffer into length, value, PIN match and range flags
module setup_entry_parse
  import setup_pkg::*;
(
  input  senhaPac_t               digitos_value_i,
  input  logic [MASTER_LEN*4-1:0] master_pin_i,
  input  logic [3:0]              idx_i,
  output logic [3:0]              key_o,
  output logic [4:0]              n_o,
  output cfg_val_t                value_o,
  output logic                    too_long_o,
  output logic                    pin_match_o,
  output logic                    in_range_o
);

  logic     done;
  cfg_val_t lo;
  cfg_val_t hi;

  always_comb begin
    key_o = digitos_value_i[0];
    n_o   = '0;
    done  = 1'b0;
    for (int i = 1; i < SENHA_NIB; i++) begin
      if (!done && digitos_value_i[i] != KEY_NONE) n_o = n_o + 5'd1;
      else done = 1'b1;
    end

    for (int j = 0; j < CFG_DIG; j++) begin
      value_o[j*4 +: 4] = (j < int'(n_o)) ? digitos_value_i[j+1] : 4'h0;
    end
    too_long_o = (n_o > 5'(CFG_DIG));

    pin_match_o = (n_o == 5'(MASTER_LEN));
    for (int i = 0; i < MASTER_LEN; i++) begin
      if (digitos_value_i[i+1] != master_pin_i[i*4 +: 4]) pin_match_o = 1'b0;
    end

    // BCD values order the same as their binary encodings.
    lo = CFG_MIN[0];
    hi = CFG_MAX[0];
    for (int i = 0; i < NUM_CFG; i++) begin
      if (idx_i == 4'(i + 1)) begin
        lo = CFG_MIN[i];
        hi = CFG_MAX[i];
      end
    end
    in_range_o = (value_o >= lo) && (value_o <= hi);
  end

endmodule

// File: rtl/setup_cfg_param.sv
// rtl/setup_cfg_param.sv - setup-mode controller: master PIN auth, per-item config walk, lockout and timeout
module setup_cfg_param
  import setup_pkg::*;
#(
  parameter int MAX_TRIES   = 3,
  parameter int LOCK_CYC    = 1000,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    setup_on_i,
  input  senhaPac_t               digitos_value_i,
  input  logic                    digitos_valid_i,
  input  logic [MASTER_LEN*4-1:0] master_pin_i,
  output logic                    display_en_o,
  output bcdPac_t                 bcd_pac_o,
  output cfg_arr_t                data_setup_new_o,
  output logic                    data_setup_ok_o,
  output logic                    entry_err_o,
  output logic                    auth_fail_o,
  output logic                    locked_o
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int LW = $clog2(LOCK_CYC + 1);
  localparam int RW = $clog2(MAX_TRIES + 1);

  state_t          state_q, state_d;
  cfg_arr_t        working_q, working_d;
  setupPac_t       pub_q, pub_d;
  bcdPac_t         bcd_q, bcd_d;
  logic [3:0]      idx_q, idx_d;
  logic [RW-1:0]   tries_q, tries_d;
  logic [TW-1:0]   tmr_q, tmr_d;
  logic [LW-1:0]   lock_cnt_q, lock_cnt_d;
  logic            locked_q, locked_d;
  logic            disp_q, disp_d;
  logic            err_q, err_d;
  logic            fail_q, fail_d;
  logic            setup_on_q;

  logic [3:0] key;
  logic [4:0] n;
  cfg_val_t   value;
  cfg_val_t   cur;
  logic       too_long, pin_match, in_range;
  logic       star, hash, idle_to, setup_rise;

  setup_entry_parse u_parse (
    .digitos_value_i (digitos_value_i),
    .master_pin_i    (master_pin_i),
    .idx_i           (idx_q),
    .key_o           (key),
    .n_o             (n),
    .value_o         (value),
    .too_long_o      (too_long),
    .pin_match_o     (pin_match),
    .in_range_o      (in_range)
  );

  assign star       = digitos_valid_i && (key == KEY_STAR);
  assign hash       = digitos_valid_i && (key == KEY_HASH);
  assign idle_to    = (state_q != ST_IDLE) && !digitos_valid_i && (tmr_q == TW'(TIMEOUT_CYC - 1));
  assign setup_rise = setup_on_i && !setup_on_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (setup_rise && !locked_q) state_d = ST_AUTH;
      ST_AUTH: begin
        if (hash || idle_to) state_d = ST_IDLE;
        else if (star) begin
          if (pin_match)                             state_d = ST_CFG;
          else if (tries_q == RW'(MAX_TRIES - 1))    state_d = ST_IDLE;
        end
      end
      ST_CFG: begin
        if (hash || idle_to)                         state_d = ST_IDLE;
        else if (star && idx_q == 4'(NUM_CFG))       state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    working_d  = working_q;
    idx_d      = idx_q;
    tries_d    = tries_q;
    pub_d      = pub_q;
    pub_d.ok   = 1'b0;
    err_d      = 1'b0;
    fail_d     = 1'b0;
    locked_d   = locked_q;
    lock_cnt_d = lock_cnt_q;

    if (locked_q) begin
      lock_cnt_d = lock_cnt_q + LW'(1);
      if (lock_cnt_d == LW'(LOCK_CYC)) locked_d = 1'b0;
    end

    case (state_q)
      ST_AUTH: if (star) begin
        if (pin_match) begin
          idx_d     = 4'd1;
          tries_d   = '0;
          working_d = pub_q.data;
        end else if (tries_q == RW'(MAX_TRIES - 1)) begin
          tries_d    = '0;
          fail_d     = 1'b1;
          locked_d   = 1'b1;
          lock_cnt_d = '0;
        end else begin
          tries_d = tries_q + RW'(1);
        end
      end
      ST_CFG: if (star) begin
        if (n != 5'd0) begin
          if (too_long || !in_range) err_d = 1'b1;
          else begin
            for (int i = 0; i < NUM_CFG; i++) begin
              if (idx_q == 4'(i + 1)) working_d[i] = value;
            end
          end
        end
        // The last item's edit is folded in before publishing.
        if (idx_q == 4'(NUM_CFG)) begin
          pub_d.data = working_d;
          pub_d.ok   = 1'b1;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      default: ;
    endcase

    if (digitos_valid_i || state_d != state_q || state_q == ST_IDLE) tmr_d = '0;
    else                                                            tmr_d = tmr_q + TW'(1);

    disp_d = (state_d != ST_IDLE);
    cur    = '0;
    for (int i = 0; i < NUM_CFG; i++) begin
      if (idx_d == 4'(i + 1)) cur = working_d[i];
    end
    bcd_d = '1;
    if (state_d == ST_CFG) begin
      bcd_d[5] = idx_d;
      for (int j = 0; j < CFG_DIG; j++) bcd_d[j] = cur[j*4 +: 4];
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      working_q  <= CFG_RST;
      pub_q      <= '{data: CFG_RST, ok: 1'b0};
      bcd_q      <= '1;
      idx_q      <= 4'd0;
      tries_q    <= '0;
      tmr_q      <= '0;
      lock_cnt_q <= '0;
      locked_q   <= 1'b0;
      disp_q     <= 1'b0;
      err_q      <= 1'b0;
      fail_q     <= 1'b0;
      setup_on_q <= 1'b0;
    end else begin
      working_q  <= working_d;
      pub_q      <= pub_d;
      bcd_q      <= bcd_d;
      idx_q      <= idx_d;
      tries_q    <= tries_d;
      tmr_q      <= tmr_d;
      lock_cnt_q <= lock_cnt_d;
      locked_q   <= locked_d;
      disp_q     <= disp_d;
      err_q      <= err_d;
      fail_q     <= fail_d;
      setup_on_q <= setup_on_i;
    end
  end

  assign display_en_o     = disp_q;
  assign bcd_pac_o        = bcd_q;
  assign data_setup_new_o = pub_q.data;
  assign data_setup_ok_o  = pub_q.ok;
  assign entry_err_o      = err_q;
  assign auth_fail_o      = fail_q;
  assign locked_o         = locked_q;

endmodule

// File: tb/tb_setup_cfg_param.sv
// tb/tb_setup_cfg_param.sv - directed self-checking bench for setup_cfg_param
module tb_setup_cfg_param;
  import setup_pkg::*;

  localparam int TO   = 300;
  localparam int LOCK = 1000;

  logic      clk = 1'b0;
  logic      rst_n = 1'b0;
  logic      setup_on = 1'b0;
  logic      dvalid = 1'b0;
  senhaPac_t dval = '1;
  logic [15:0] mpin = 16'h1234;
  logic      disp, ok, err, fail, locked;
  bcdPac_t   bcd;
  cfg_arr_t  data;

  int errors = 0;
  int checks = 0;
  senhaPac_t kbuf = '1;
  logic ok_s, err_s, fail_s;
  logic [15:0] rst_tab [8] = '{16'h0030, 16'h0010, 16'h0005, 16'h0100,
                               16'h0002, 16'h0060, 16'h1234, 16'h0000};
  logic [15:0] exp_tab [8];

  setup_cfg_param #(.MAX_TRIES(3), .LOCK_CYC(LOCK), .TIMEOUT_CYC(TO)) dut (
    .clk_i            (clk),
    .rst_i            (rst_n),
    .setup_on_i       (setup_on),
    .digitos_value_i  (dval),
    .digitos_valid_i  (dvalid),
    .master_pin_i     (mpin),
    .display_en_o     (disp),
    .bcd_pac_o        (bcd),
    .data_setup_new_o (data),
    .data_setup_ok_o  (ok),
    .entry_err_o      (err),
    .auth_fail_o      (fail),
    .locked_o         (locked)
  );

  always #5 clk = ~clk;

  function automatic cfg_arr_t pack_tab(input logic [15:0] t [8]);
    cfg_arr_t r;
    for (int i = 0; i < 8; i++) r[i] = t[i];
    return r;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [3:0] k);
    kbuf = {kbuf[SENHA_NIB-2:0], k};
    dval = kbuf;
    dvalid = 1'b1;
    @(negedge clk);
    dvalid = 1'b0;
    ok_s = ok; err_s = err; fail_s = fail;
    if (k == KEY_STAR || k == KEY_HASH) kbuf = '1;
  endtask

  task automatic enter(input int ndig, input logic [23:0] digits);
    for (int i = ndig - 1; i >= 0; i--) press(digits[i*4 +: 4]);
    press(KEY_STAR);
  endtask

  task automatic start_setup();
    setup_on = 1'b1;
    @(negedge clk);
    setup_on = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(10);
    checks++; if (disp !== 1'b0) begin errors++; $display("FAIL reset_disp: got %b want 0", disp); end
    checks++; if (bcd !== 24'hFFFFFF) begin errors++; $display("FAIL reset_bcd: got %h want ffffff", bcd); end
    checks++; if (data !== pack_tab(rst_tab)) begin errors++; $display("FAIL reset_data: got %h want %h", data, pack_tab(rst_tab)); end
    checks++; if ({ok, err, fail, locked} !== 4'b0) begin errors++; $display("FAIL reset_flags: got %b want 0000", {ok, err, fail, locked}); end
    rst_n = 1'b1;
    tick(2);
  endtask

  task automatic test_walk();
    logic [23:0] e;
    start_setup();
    checks++; if (disp !== 1'b1) begin errors++; $display("FAIL walk_enter: got %b want 1", disp); end
    checks++; if (bcd !== 24'hFFFFFF) begin errors++; $display("FAIL walk_auth_bcd: got %h want ffffff", bcd); end
    enter(4, 24'h1234);
    checks++; if (bcd !== 24'h1F0030) begin errors++; $display("FAIL walk_item1: got %h want 1f0030", bcd); end
    for (int k = 1; k < 8; k++) begin
      press(KEY_STAR);
      e = {4'(k + 1), 4'hF, rst_tab[k]};
      checks++; if (bcd !== e) begin errors++; $display("FAIL walk_step%0d: got %h want %h", k, bcd, e); end
    end
    press(KEY_STAR);
    checks++; if (ok_s !== 1'b1) begin errors++; $display("FAIL walk_ok: got %b want 1", ok_s); end
    checks++; if (disp !== 1'b0 || bcd !== 24'hFFFFFF) begin errors++; $display("FAIL walk_exit: got disp=%b bcd=%h want 0 ffffff", disp, bcd); end
    checks++; if (data !== pack_tab(exp_tab)) begin errors++; $display("FAIL walk_data: got %h want %h", data, pack_tab(exp_tab)); end
  endtask

  task automatic test_edit();
    start_setup();
    enter(4, 24'h1234);
    enter(2, 24'h50);
    checks++; if (err_s !== 1'b0) begin errors++; $display("FAIL edit_err: got %b want 0", err_s); end
    checks++; if (bcd !== 24'h2F0010) begin errors++; $display("FAIL edit_bcd: got %h want 2f0010", bcd); end
    repeat (7) press(KEY_STAR);
    exp_tab[0] = 16'h0050;
    checks++; if (ok_s !== 1'b1) begin errors++; $display("FAIL edit_ok: got %b want 1", ok_s); end
    checks++; if (data !== pack_tab(exp_tab)) begin errors++; $display("FAIL edit_data: got %h want %h", data, pack_tab(exp_tab)); end
  endtask

  task automatic test_range();
    start_setup();
    enter(4, 24'h1234);
    checks++; if (bcd !== 24'h1F0050) begin errors++; $display("FAIL range_load: got %h want 1f0050", bcd); end
    enter(1, 24'h5);
    checks++; if (err_s !== 1'b1 || bcd !== 24'h2F0010) begin errors++; $display("FAIL range_below: got err=%b bcd=%h want 1 2f0010", err_s, bcd); end
    enter(2, 24'h75);
    checks++; if (err_s !== 1'b1 || bcd !== 24'h3F0005) begin errors++; $display("FAIL range_above: got err=%b bcd=%h want 1 3f0005", err_s, bcd); end
    enter(5, 24'h12345);
    checks++; if (err_s !== 1'b1 || bcd !== 24'h4F0100) begin errors++; $display("FAIL range_long: got err=%b bcd=%h want 1 4f0100", err_s, bcd); end
    enter(4, 24'h4999);
    checks++; if (err_s !== 1'b0 || bcd !== 24'h5F0002) begin errors++; $display("FAIL range_ok: got err=%b bcd=%h want 0 5f0002", err_s, bcd); end
    enter(1, 24'h9);
    checks++; if (err_s !== 1'b0 || bcd !== 24'h6F0060) begin errors++; $display("FAIL range_max: got err=%b bcd=%h want 0 6f0060", err_s, bcd); end
    enter(1, 24'h0);
    checks++; if (err_s !== 1'b0 || bcd !== 24'h7F1234) begin errors++; $display("FAIL range_min: got err=%b bcd=%h want 0 7f1234", err_s, bcd); end
    press(KEY_STAR);
    checks++; if (err_s !== 1'b0 || bcd !== 24'h8F0000) begin errors++; $display("FAIL range_empty: got err=%b bcd=%h want 0 8f0000", err_s, bcd); end
    press(KEY_STAR);
    exp_tab[3] = 16'h4999; exp_tab[4] = 16'h0009; exp_tab[5] = 16'h0000;
    checks++; if (ok_s !== 1'b1) begin errors++; $display("FAIL range_ok_pulse: got %b want 1", ok_s); end
    checks++; if (data !== pack_tab(exp_tab)) begin errors++; $display("FAIL range_data: got %h want %h", data, pack_tab(exp_tab)); end
  endtask

  task automatic test_lockout();
    start_setup();
    for (int t = 0; t < 2; t++) begin
      enter(4, 24'h9999);
      checks++; if (fail_s !== 1'b0 || disp !== 1'b1) begin errors++; $display("FAIL lock_try%0d: got fail=%b disp=%b want 0 1", t, fail_s, disp); end
    end
    enter(4, 24'h9999);
    checks++; if (fail_s !== 1'b1 || locked !== 1'b1 || disp !== 1'b0) begin errors++; $display("FAIL lock_fail: got fail=%b locked=%b disp=%b want 1 1 0", fail_s, locked, disp); end
    start_setup();
    checks++; if (disp !== 1'b0) begin errors++; $display("FAIL lock_ignore1: got %b want 0", disp); end
    tick(900);
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL lock_hold: got %b want 1", locked); end
    start_setup();
    checks++; if (disp !== 1'b0) begin errors++; $display("FAIL lock_ignore2: got %b want 0", disp); end
    tick(120);
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL lock_release: got %b want 0", locked); end
    start_setup();
    checks++; if (disp !== 1'b1) begin errors++; $display("FAIL lock_reenter: got %b want 1", disp); end
    enter(4, 24'h9999);
    checks++; if (fail_s !== 1'b0 || disp !== 1'b1) begin errors++; $display("FAIL lock_tries_clr: got fail=%b disp=%b want 0 1", fail_s, disp); end
    enter(4, 24'h1234);
    checks++; if (bcd !== 24'h1F0050) begin errors++; $display("FAIL lock_auth: got %h want 1f0050", bcd); end
    press(KEY_HASH);
    checks++; if (disp !== 1'b0 || ok_s !== 1'b0) begin errors++; $display("FAIL lock_exit: got disp=%b ok=%b want 0 0", disp, ok_s); end
  endtask

  task automatic test_abort();
    int seen_ok;
    start_setup();
    enter(4, 24'h1234);
    enter(2, 24'h44);
    press(KEY_HASH);
    checks++; if (disp !== 1'b0 || ok_s !== 1'b0) begin errors++; $display("FAIL abort_hash: got disp=%b ok=%b want 0 0", disp, ok_s); end
    checks++; if (data !== pack_tab(exp_tab)) begin errors++; $display("FAIL abort_hash_data: got %h want %h", data, pack_tab(exp_tab)); end

    start_setup();
    enter(4, 24'h1234);
    enter(2, 24'h44);
    seen_ok = 0;
    for (int c = 0; c < TO - 20; c++) begin
      @(negedge clk);
      if (ok === 1'b1) seen_ok++;
    end
    checks++; if (disp !== 1'b1) begin errors++; $display("FAIL timeout_early: got %b want 1", disp); end
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (ok === 1'b1) seen_ok++;
    end
    checks++; if (disp !== 1'b0) begin errors++; $display("FAIL timeout_exit: got %b want 0", disp); end
    checks++; if (seen_ok != 0) begin errors++; $display("FAIL timeout_ok: got %0d pulses want 0", seen_ok); end
    checks++; if (data !== pack_tab(exp_tab)) begin errors++; $display("FAIL timeout_data: got %h want %h", data, pack_tab(exp_tab)); end

    start_setup();
    enter(4, 24'h1234);
    enter(2, 24'h44);
    rst_n = 1'b0;
    tick(2);
    checks++; if (disp !== 1'b0 || ok !== 1'b0) begin errors++; $display("FAIL rst_mid: got disp=%b ok=%b want 0 0", disp, ok); end
    checks++; if (data !== pack_tab(rst_tab)) begin errors++; $display("FAIL rst_mid_data: got %h want %h", data, pack_tab(rst_tab)); end
    rst_n = 1'b1;
    tick(1);
    start_setup();
    enter(4, 24'h1234);
    checks++; if (bcd !== 24'h1F0030) begin errors++; $display("FAIL rst_working: got %h want 1f0030", bcd); end
    press(KEY_HASH);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) exp_tab[i] = rst_tab[i];
    test_reset();
    test_walk();
    test_edit();
    test_range();
    test_lockout();
    test_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
